// File: rtl/dpram_be.sv
// dpram_be: true dual-port synchronous RAM with per-byte write enables.
//
// Successor to the j1a core's fixed 16-bit two-port memory. Port A serves
// data/IO and port B instruction fetch (or a debug/loader master). Both
// ports share one clock.
//
// Pipeline:
//   - Edge N registers the request.
//   - Edge N+1 performs the memory access and registers read data,
//     collision and the collision count.
//   - With OUT_REG=1, edge N+2 re-registers the read data and valid.
//
// Ports:
//   clk                 single clock for both ports
//   reset               synchronous, active-high; clears the pipeline and
//                       suppresses writes; memory contents are kept
//   en_a / en_b         access strobe
//   we_a / we_b         byte write enables; all zero means a read
//   addr_a / addr_b     word address
//   wdata_a / wdata_b   write data
//   rdata_a / rdata_b   read data; holds its value between valid results
//   rvalid_a / rvalid_b one-cycle read-data-valid pulse
//   collision           one-cycle pulse for a same-address access in which
//                       at least one port writes
//   coll_count          saturating 16-bit count of collision events
module dpram_be #(
    parameter int DWIDTH        = 16,
    parameter int LOG2ABITS     = 11,
    parameter int BEWIDTH       = DWIDTH / 8,
    parameter     MEM_INIT_FILE = "",
    parameter int WRITE_MODE    = 0,
    parameter int OUT_REG       = 0,
    parameter int COLL_PRIO     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_a,
    input  logic [BEWIDTH-1:0]   we_a,
    input  logic [LOG2ABITS-1:0] addr_a,
    input  logic [DWIDTH-1:0]    wdata_a,
    output logic [DWIDTH-1:0]    rdata_a,
    output logic                 rvalid_a,
    input  logic                 en_b,
    input  logic [BEWIDTH-1:0]   we_b,
    input  logic [LOG2ABITS-1:0] addr_b,
    input  logic [DWIDTH-1:0]    wdata_b,
    output logic [DWIDTH-1:0]    rdata_b,
    output logic                 rvalid_b,
    output logic                 collision,
    output logic [15:0]          coll_count
);

    localparam int DEPTH      = 2 ** LOG2ABITS;
    localparam bit PRIO_B     = (COLL_PRIO != 0);
    localparam bit READ_FIRST = (WRITE_MODE == 1);
    localparam bit NO_CHANGE  = (WRITE_MODE == 0);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Replaces the lanes of base selected by be with the lanes of wd.
    function automatic logic [DWIDTH-1:0] merge_bytes(
        input logic [DWIDTH-1:0]  base,
        input logic [DWIDTH-1:0]  wd,
        input logic [BEWIDTH-1:0] be
    );
        logic [DWIDTH-1:0] r;
        r = base;
        for (int i = 0; i < BEWIDTH; i++) begin
            if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        end
        return r;
    endfunction

    // Saturating increment: the count sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // ---------------- stage p0: request registers (edge N) ----------------
    logic                 acc_a_p0_q, acc_b_p0_q;
    logic [BEWIDTH-1:0]   we_a_p0_q, we_b_p0_q;
    logic [LOG2ABITS-1:0] addr_a_p0_q, addr_b_p0_q;
    logic [DWIDTH-1:0]    wdata_a_p0_q, wdata_b_p0_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_a_p0_q   <= 1'b0;
            acc_b_p0_q   <= 1'b0;
            we_a_p0_q    <= '0;
            we_b_p0_q    <= '0;
            addr_a_p0_q  <= '0;
            addr_b_p0_q  <= '0;
            wdata_a_p0_q <= '0;
            wdata_b_p0_q <= '0;
        end else begin
            acc_a_p0_q   <= en_a;
            acc_b_p0_q   <= en_b;
            we_a_p0_q    <= we_a;
            we_b_p0_q    <= we_b;
            addr_a_p0_q  <= addr_a;
            addr_b_p0_q  <= addr_b;
            wdata_a_p0_q <= wdata_a;
            wdata_b_p0_q <= wdata_b;
        end
    end

    // ---------------- stage p1: memory access (edge N+1) ----------------
    logic [DWIDTH-1:0]  old_a, old_b;
    logic [DWIDTH-1:0]  final_a, final_b;
    logic [DWIDTH-1:0]  rdata_a_d, rdata_b_d;
    logic [BEWIDTH-1:0] lose_a, lose_b;
    logic [BEWIDTH-1:0] eff_we_a, eff_we_b;
    logic               both_same, rvalid_a_d, rvalid_b_d, coll_d;

    assign old_a     = mem[addr_a_p0_q];
    assign old_b     = mem[addr_b_p0_q];
    assign both_same = acc_a_p0_q && acc_b_p0_q && (addr_a_p0_q == addr_b_p0_q);
    assign coll_d    = both_same && ((we_a_p0_q != '0) || (we_b_p0_q != '0));

    always_comb begin
        lose_a = '0;
        lose_b = '0;
        // On a same-address double write, the non-priority port gives up
        // every lane the priority port also writes.
        if (both_same) begin
            if (PRIO_B) lose_a = we_b_p0_q;
            else        lose_b = we_a_p0_q;
        end
        eff_we_a = acc_a_p0_q ? (we_a_p0_q & ~lose_a) : '0;
        eff_we_b = acc_b_p0_q ? (we_b_p0_q & ~lose_b) : '0;

        // Effective lanes are disjoint on a shared address, so both ports
        // compute the same stored word there.
        final_a = merge_bytes(merge_bytes(old_a, wdata_a_p0_q, eff_we_a),
                              wdata_b_p0_q, both_same ? eff_we_b : '0);
        final_b = merge_bytes(merge_bytes(old_b, wdata_b_p0_q, eff_we_b),
                              wdata_a_p0_q, both_same ? eff_we_a : '0);

        // Reads, and READ_FIRST writes, return the pre-write word.
        rdata_a_d  = ((we_a_p0_q == '0) || READ_FIRST) ? old_a : final_a;
        rdata_b_d  = ((we_b_p0_q == '0) || READ_FIRST) ? old_b : final_b;
        rvalid_a_d = acc_a_p0_q && ((we_a_p0_q == '0) || !NO_CHANGE);
        rvalid_b_d = acc_b_p0_q && ((we_b_p0_q == '0) || !NO_CHANGE);
    end

    // A write still pending when reset rises is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (eff_we_a != '0) mem[addr_a_p0_q] <= final_a;
            if (eff_we_b != '0) mem[addr_b_p0_q] <= final_b;
        end
    end

    logic [DWIDTH-1:0] rdata_a_p1_q, rdata_b_p1_q;
    logic              rvalid_a_p1_q, rvalid_b_p1_q;
    logic              collision_q;
    logic [15:0]       coll_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_a_p1_q  <= '0;
            rdata_b_p1_q  <= '0;
            rvalid_a_p1_q <= 1'b0;
            rvalid_b_p1_q <= 1'b0;
            collision_q   <= 1'b0;
            coll_count_q  <= '0;
        end else begin
            rvalid_a_p1_q <= rvalid_a_d;
            rvalid_b_p1_q <= rvalid_b_d;
            if (rvalid_a_d) rdata_a_p1_q <= rdata_a_d;
            if (rvalid_b_d) rdata_b_p1_q <= rdata_b_d;
            collision_q <= coll_d;
            if (coll_d) coll_count_q <= sat_inc(coll_count_q);
        end
    end

    assign collision  = collision_q;
    assign coll_count = coll_count_q;

    // ---------------- stage p2: optional output register (edge N+2) ----------------
    if (OUT_REG != 0) begin : g_oreg
        logic [DWIDTH-1:0] rdata_a_p2_q, rdata_b_p2_q;
        logic              rvalid_a_p2_q, rvalid_b_p2_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_a_p2_q  <= '0;
                rdata_b_p2_q  <= '0;
                rvalid_a_p2_q <= 1'b0;
                rvalid_b_p2_q <= 1'b0;
            end else begin
                rvalid_a_p2_q <= rvalid_a_p1_q;
                rvalid_b_p2_q <= rvalid_b_p1_q;
                if (rvalid_a_p1_q) rdata_a_p2_q <= rdata_a_p1_q;
                if (rvalid_b_p1_q) rdata_b_p2_q <= rdata_b_p1_q;
            end
        end

        assign rdata_a  = rdata_a_p2_q;
        assign rdata_b  = rdata_b_p2_q;
        assign rvalid_a = rvalid_a_p2_q;
        assign rvalid_b = rvalid_b_p2_q;
    end else begin : g_noreg
        assign rdata_a  = rdata_a_p1_q;
        assign rdata_b  = rdata_b_p1_q;
        assign rvalid_a = rvalid_a_p1_q;
        assign rvalid_b = rvalid_b_p1_q;
    end

endmodule

// File: tb/tb_dpram_be.sv
// Directed bench for dpram_be with three configurations driven in parallel:
//   u0: NO_CHANGE,   OUT_REG=0, COLL_PRIO=A
//   u1: READ_FIRST,  OUT_REG=1, COLL_PRIO=B
//   u2: WRITE_FIRST, OUT_REG=0, COLL_PRIO=A
// Words that a preload file would supply are written through the ports first.
module tb_dpram_be;

    logic        clk = 1'b0;
    logic        reset;
    logic        en_a, en_b;
    logic [1:0]  we_a, we_b;
    logic [10:0] addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;

    logic [15:0] rda [3];
    logic [15:0] rdb [3];
    logic        rva [3];
    logic        rvb [3];
    logic        col [3];
    logic [15:0] cnt [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dpram_be #(.DWIDTH(16), .LOG2ABITS(11), .MEM_INIT_FILE(""), .WRITE_MODE(0),
               .OUT_REG(0), .COLL_PRIO(0)) u0 (
        .clk(clk), .reset(reset),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rda[0]), .rvalid_a(rva[0]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdb[0]), .rvalid_b(rvb[0]),
        .collision(col[0]), .coll_count(cnt[0]));

    dpram_be #(.DWIDTH(16), .LOG2ABITS(11), .MEM_INIT_FILE(""), .WRITE_MODE(1),
               .OUT_REG(1), .COLL_PRIO(1)) u1 (
        .clk(clk), .reset(reset),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rda[1]), .rvalid_a(rva[1]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdb[1]), .rvalid_b(rvb[1]),
        .collision(col[1]), .coll_count(cnt[1]));

    dpram_be #(.DWIDTH(16), .LOG2ABITS(11), .MEM_INIT_FILE(""), .WRITE_MODE(2),
               .OUT_REG(0), .COLL_PRIO(0)) u2 (
        .clk(clk), .reset(reset),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .rdata_a(rda[2]), .rvalid_a(rva[2]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .rdata_b(rdb[2]), .rvalid_b(rvb[2]),
        .collision(col[2]), .coll_count(cnt[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; en_b = 1'b0; we_a = 2'b00; we_b = 2'b00;
    endtask

    task automatic op_a(input logic [1:0] we, input logic [10:0] ad, input logic [15:0] d);
        en_a = 1'b1; we_a = we; addr_a = ad; wdata_a = d;
    endtask

    task automatic op_b(input logic [1:0] we, input logic [10:0] ad, input logic [15:0] d);
        en_b = 1'b1; we_b = we; addr_b = ad; wdata_b = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rda[i] !== 16'h0000 || rdb[i] !== 16'h0000) begin
                bad++;
                $display("FAIL reset_rdata u%0d got a=%h b=%h exp 0000", i, rda[i], rdb[i]);
            end
            total++;
            if (rva[i] !== 1'b0 || rvb[i] !== 1'b0 || col[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_flags u%0d got rva=%b rvb=%b col=%b exp 0", i, rva[i], rvb[i], col[i]);
            end
            total++;
            if (cnt[i] !== 16'h0000) begin
                bad++;
                $display("FAIL reset_count u%0d got=%h exp=0000", i, cnt[i]);
            end
        end
    endtask

    task automatic fill();
        reset = 1'b0;
        op_a(2'b11, 11'h7FF, 16'h07FF); op_b(2'b11, 11'h000, 16'h0000); tick();
        op_a(2'b11, 11'h007, 16'h0007); op_b(2'b11, 11'h002, 16'h5A5A); tick();
        idle(); tick(); tick(); tick();
    endtask

    task automatic test_preload_read();
        op_a(2'b00, 11'h7FF, 16'h0); op_b(2'b00, 11'h000, 16'h0);
        tick();           // edge N
        idle();
        tick();           // edge N+1
        for (int i = 0; i < 3; i += 2) begin
            total++;
            if (rda[i] !== 16'h07FF || rva[i] !== 1'b1) begin
                bad++;
                $display("FAIL top_addr_read u%0d got=%h/%b exp=07ff/1", i, rda[i], rva[i]);
            end
            total++;
            if (rdb[i] !== 16'h0000 || rvb[i] !== 1'b1) begin
                bad++;
                $display("FAIL zero_addr_read u%0d got=%h/%b exp=0000/1", i, rdb[i], rvb[i]);
            end
        end
        total++;
        if (rva[1] !== 1'b0) begin
            bad++;
            $display("FAIL outreg_early_valid u1 got=%b exp=0", rva[1]);
        end
        tick();           // edge N+2
        total++;
        if (rda[1] !== 16'h07FF || rva[1] !== 1'b1 || rdb[1] !== 16'h0000 || rvb[1] !== 1'b1) begin
            bad++;
            $display("FAIL outreg_read u1 got a=%h/%b b=%h/%b exp 07ff/1 0000/1", rda[1], rva[1], rdb[1], rvb[1]);
        end
        total++;
        if (rva[0] !== 1'b0) begin
            bad++;
            $display("FAIL valid_pulse u0 got=%b exp=0", rva[0]);
        end
    endtask

    task automatic test_byte_enable();
        op_a(2'b11, 11'h005, 16'hABCD); tick();
        op_a(2'b01, 11'h005, 16'h1234); tick();
        op_a(2'b00, 11'h005, 16'h0000); tick();
        idle(); tick();
        for (int i = 0; i < 3; i += 2) begin
            total++;
            if (rda[i] !== 16'hAB34 || rva[i] !== 1'b1) begin
                bad++;
                $display("FAIL byte_enable u%0d got=%h/%b exp=ab34/1", i, rda[i], rva[i]);
            end
        end
        tick();
        total++;
        if (rda[1] !== 16'hAB34 || rva[1] !== 1'b1) begin
            bad++;
            $display("FAIL byte_enable u1 got=%h/%b exp=ab34/1", rda[1], rva[1]);
        end
    endtask

    task automatic test_write_modes();
        op_a(2'b11, 11'h009, 16'h1111); tick();
        op_a(2'b00, 11'h005, 16'h0000); tick();
        idle(); tick(); tick(); tick();
        op_a(2'b11, 11'h009, 16'h2222);
        tick();           // edge N
        idle();
        tick();           // edge N+1
        total++;
        if (rda[0] !== 16'hAB34 || rva[0] !== 1'b0) begin
            bad++;
            $display("FAIL no_change u0 got=%h/%b exp=ab34/0", rda[0], rva[0]);
        end
        total++;
        if (rda[2] !== 16'h2222 || rva[2] !== 1'b1) begin
            bad++;
            $display("FAIL write_first u2 got=%h/%b exp=2222/1", rda[2], rva[2]);
        end
        tick();           // edge N+2
        total++;
        if (rda[1] !== 16'h1111 || rva[1] !== 1'b1) begin
            bad++;
            $display("FAIL read_first u1 got=%h/%b exp=1111/1", rda[1], rva[1]);
        end
    endtask

    task automatic test_double_write();
        logic [15:0] exp_m [3];
        exp_m[0] = 16'hAAAA; exp_m[1] = 16'hBBAA; exp_m[2] = 16'hAAAA;
        op_a(2'b11, 11'h003, 16'hAAAA); op_b(2'b10, 11'h003, 16'hBBBB);
        tick();
        idle();
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (col[i] !== 1'b1 || cnt[i] !== 16'd1) begin
                bad++;
                $display("FAIL dw_collision u%0d got col=%b cnt=%h exp 1/0001", i, col[i], cnt[i]);
            end
        end
        total++;
        if (rda[2] !== 16'hAAAA || rdb[2] !== 16'hAAAA) begin
            bad++;
            $display("FAIL dw_write_first u2 got a=%h b=%h exp aaaa", rda[2], rdb[2]);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (col[i] !== 1'b0 || cnt[i] !== 16'd1) begin
                bad++;
                $display("FAIL dw_pulse u%0d got col=%b cnt=%h exp 0/0001", i, col[i], cnt[i]);
            end
        end
        op_a(2'b00, 11'h003, 16'h0); tick();
        idle(); tick();
        for (int i = 0; i < 3; i += 2) begin
            total++;
            if (rda[i] !== exp_m[i]) begin
                bad++;
                $display("FAIL dw_mem u%0d got=%h exp=%h", i, rda[i], exp_m[i]);
            end
        end
        tick();
        total++;
        if (rda[1] !== exp_m[1]) begin
            bad++;
            $display("FAIL dw_mem u1 got=%h exp=%h", rda[1], exp_m[1]);
        end
    endtask

    task automatic test_rw_collision();
        op_a(2'b00, 11'h007, 16'h0); op_b(2'b11, 11'h007, 16'hFFFF);
        tick();
        idle();
        tick();
        for (int i = 0; i < 3; i += 2) begin
            total++;
            if (rda[i] !== 16'h0007 || rva[i] !== 1'b1) begin
                bad++;
                $display("FAIL rw_old_word u%0d got=%h/%b exp=0007/1", i, rda[i], rva[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (col[i] !== 1'b1 || cnt[i] !== 16'd2) begin
                bad++;
                $display("FAIL rw_collision u%0d got col=%b cnt=%h exp 1/0002", i, col[i], cnt[i]);
            end
        end
        total++;
        if (rdb[2] !== 16'hFFFF) begin
            bad++;
            $display("FAIL rw_writer_wf u2 got=%h exp=ffff", rdb[2]);
        end
        tick();
        total++;
        if (rda[1] !== 16'h0007 || rdb[1] !== 16'h0007) begin
            bad++;
            $display("FAIL rw_read_first u1 got a=%h b=%h exp 0007", rda[1], rdb[1]);
        end
        op_a(2'b00, 11'h007, 16'h0); tick();
        idle(); tick();
        for (int i = 0; i < 3; i += 2) begin
            total++;
            if (rda[i] !== 16'hFFFF) begin
                bad++;
                $display("FAIL rw_new_word u%0d got=%h exp=ffff", i, rda[i]);
            end
        end
        tick();
        total++;
        if (rda[1] !== 16'hFFFF) begin
            bad++;
            $display("FAIL rw_new_word u1 got=%h exp=ffff", rda[1]);
        end
    endtask

    task automatic test_saturation();
        op_a(2'b00, 11'h008, 16'h0); op_b(2'b11, 11'h008, 16'h0);
        repeat (70000) tick();
        idle();
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (cnt[i] !== 16'hFFFF || col[i] !== 1'b0) begin
                bad++;
                $display("FAIL saturation u%0d got cnt=%h col=%b exp ffff/0", i, cnt[i], col[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        op_a(2'b00, 11'h7FF, 16'h0);
        tick();                                  // read accepted, still pending
        idle();
        op_b(2'b11, 11'h002, 16'h0F0F);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rda[i] !== 16'h0 || rdb[i] !== 16'h0 || rva[i] !== 1'b0 || rvb[i] !== 1'b0 ||
                col[i] !== 1'b0 || cnt[i] !== 16'h0) begin
                bad++;
                $display("FAIL mid_reset u%0d got a=%h b=%h rva=%b rvb=%b col=%b cnt=%h exp all 0",
                         i, rda[i], rdb[i], rva[i], rvb[i], col[i], cnt[i]);
            end
        end
        reset = 1'b0;
        idle();
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rva[i] !== 1'b0 || rvb[i] !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_valid u%0d got %b/%b exp 0/0", i, rva[i], rvb[i]);
            end
        end
        op_a(2'b00, 11'h002, 16'h0); op_b(2'b00, 11'h7FF, 16'h0);
        tick();
        idle();
        tick();
        for (int i = 0; i < 3; i += 2) begin
            total++;
            if (rda[i] !== 16'h5A5A || rdb[i] !== 16'h07FF) begin
                bad++;
                $display("FAIL post_reset_mem u%0d got a=%h b=%h exp 5a5a 07ff", i, rda[i], rdb[i]);
            end
        end
        tick();
        total++;
        if (rda[1] !== 16'h5A5A || rdb[1] !== 16'h07FF) begin
            bad++;
            $display("FAIL post_reset_mem u1 got a=%h b=%h exp 5a5a 07ff", rda[1], rdb[1]);
        end
    endtask

    initial begin
        test_reset();
        fill();
        test_preload_read();
        test_byte_enable();
        test_write_modes();
        test_double_write();
        test_rw_collision();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
